metronome_tempo_ctrl: RTL and testbench
=======================================

// Module: metronome_tempo_ctrl
// PURPOSE
//  Front end of the metronome: conditions the two raw active-low push buttons
//  (2-flop sync + debounce), holds a 4-bit tempo index (A = slower, B = faster)
//  and maps it to bpm_ticks, the beat period in sys_clk cycles consumed by the beat counter.
// PARAMETERS
//  FREQ             24_000_000  sys_clk frequency in Hz; must be < 2^26
//  DEBOUNCE_CYCLES  240_000     consecutive stable cycles needed to accept a level change (>=2)
//  SPEED_INIT       4'd1        tempo index loaded at reset
// PORTS
//  sys_clk          in   1   single clock; all flops on posedge
//  sys_rst_n        in   1   reset: synchronous, active-low
//  button_a_n       in   1   raw async button A, active-low (tempo down)
//  button_b_n       in   1   raw async button B, active-low (tempo up)
//  button_a_state   out  1   debounced level of A, 1 = pressed
//  button_b_state   out  1   debounced level of B, 1 = pressed
//  button_a_pressed out  1   one-cycle pulse on debounced A 0->1
//  button_b_pressed out  1   one-cycle pulse on debounced B 0->1
//  speed            out  4   tempo index, registered
//  bpm              out  8   beats/min = 60 + 10*speed (60..210)
//  bpm_ticks        out  26  floor(FREQ*60/bpm), combinational from speed
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at posedge): sync flops, debounced states, debounce counters,
//    pulses -> 0; speed -> SPEED_INIT. Mid-operation reset discards any pending press.
//  - Sync: per button, in = ~button_x_n fed through 2 flops; no logic between them.
//  - Debounce: counter clears whenever synced input == state. While synced input != state,
//    the counter increments each cycle. On the cycle it would reach DEBOUNCE_CYCLES, state
//    toggles, counter clears, and pressed (0->1) pulses for exactly 1 cycle. Any glitch
//    shorter than DEBOUNCE_CYCLES leaves state unchanged. Releases are debounced the same
//    way and produce no pulse.
//  - Latency: button held low from before edge 0 -> state=1 and pressed=1 after edge
//    2+DEBOUNCE_CYCLES; speed changes on the following edge.
//  - Speed: pressed_a -> speed-1; else pressed_b -> speed+1. A has priority when both
//    pulse in the same cycle (B's pulse is lost). Modulo 16: 0-1=15, 15+1=0.
//  - bpm_ticks: pure function of speed, 26-bit unsigned, integer floor division.
//    speed=0 -> 24_000_000; speed=1 -> 20_571_428; speed=15 (210) -> 6_857_142 at default FREQ.
//    Table is computed at elaboration (constant function); no runtime divider.
// STRUCTURE
//  - Package metronome_pkg: BPM_BASE=60, BPM_STEP=10, SPEED_W=4, TICKS_W=26,
//    function bpm_to_ticks(freq, bpm).
//  - Sub-module button_conditioner (sync + debounce, one button), instantiated twice.
//  - Top contains the speed register and the speed->bpm/bpm_ticks lookup.
// TESTING (DEBOUNCE_CYCLES=8)
//  1 Reset: hold sys_rst_n=0 2 cycles -> speed=1, bpm=70, bpm_ticks=20_571_428,
//    all states and pulses 0.
//  2 Press B clean, hold 20 cycles -> button_b_pressed single pulse 10 edges after the
//    press; speed=2, bpm=80, bpm_ticks=18_000_000; no second pulse on release.
//  3 Bounce A: low 3 cycles, high 2, low 4, high -> no pulse, speed unchanged.
//  4 Wrap: from speed=1 press A twice -> 0 then 15 (bpm_ticks=6_857_142);
//    press B -> 0 (24_000_000).
//  5 Press A and B at the same edge -> speed decrements by exactly 1.
//  6 Assert reset while a press is mid-debounce (counter=5) -> no pulse afterwards;
//    speed=SPEED_INIT.

Source files
------------

// File: rtl/metronome_tempo_ctrl_pkg.sv
// Shared constants and the bpm -> beat-period helper for the metronome tempo front end.
package metronome_pkg;

    localparam int BPM_BASE = 60;
    localparam int BPM_STEP = 10;
    localparam int SPEED_W  = 4;
    localparam int TICKS_W  = 26;

    // Beat period in clock cycles, floor(freq*60/bpm); only ever evaluated at elaboration.
    function automatic logic [TICKS_W-1:0] bpm_to_ticks(input longint unsigned freq,
                                                        input longint unsigned bpm);
        longint unsigned t;
        t = (freq * 64'd60) / bpm;
        return t[TICKS_W-1:0];
    endfunction

endpackage

// File: rtl/metronome_tempo_ctrl_if.sv
// Button inputs and tempo outputs of the metronome front end.
interface metronome_tempo_ctrl_if;
    import metronome_pkg::*;

    logic                 button_a_n;
    logic                 button_b_n;
    logic                 button_a_state;
    logic                 button_b_state;
    logic                 button_a_pressed;
    logic                 button_b_pressed;
    logic [SPEED_W-1:0]   speed;
    logic [7:0]           bpm;
    logic [TICKS_W-1:0]   bpm_ticks;

    // Buttons are plain levels and outputs are free-running status; no handshake is involved.
    modport master (
        output button_a_n, button_b_n,
        input  button_a_state, button_b_state, button_a_pressed, button_b_pressed,
        input  speed, bpm, bpm_ticks
    );

    modport slave (
        input  button_a_n, button_b_n,
        output button_a_state, button_b_state, button_a_pressed, button_b_pressed,
        output speed, bpm, bpm_ticks
    );

endinterface

// File: rtl/metronome_tempo_ctrl_button_conditioner.sv
// One active-low raw button: 2-flop synchroniser, debounce counter, press pulse.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic button_n_i,
    output logic state_o,
    output logic pressed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic             pressed_q, pressed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter runs only while the synced level disagrees with the accepted state.
    always_comb begin
        state_d   = state_q;
        pressed_d = 1'b0;
        cnt_d     = '0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                state_d   = ~state_q;
                pressed_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= ~button_n_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state_o   = state_q;
    assign pressed_o = pressed_q;

endmodule

// File: rtl/metronome_tempo_ctrl.sv
// Tempo front end: two conditioned buttons step a 4-bit tempo index mapped to bpm and beat period.
module metronome_tempo_ctrl
    import metronome_pkg::*;
#(
    parameter int unsigned       FREQ            = 24_000_000,
    parameter int unsigned       DEBOUNCE_CYCLES = 240_000,
    parameter logic [SPEED_W-1:0] SPEED_INIT     = 4'd1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    metronome_tempo_ctrl_if.slave bus
);

    logic                 a_pressed, b_pressed;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [TICKS_W-1:0]   ticks_lut [1 << SPEED_W];

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .button_n_i(bus.button_a_n),
        .state_o   (bus.button_a_state),
        .pressed_o (a_pressed)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .button_n_i(bus.button_b_n),
        .state_o   (bus.button_b_state),
        .pressed_o (b_pressed)
    );

    // A wins a same-cycle collision; the index wraps modulo 16 in both directions.
    always_comb begin
        speed_d = speed_q;
        if (a_pressed) begin
            speed_d = speed_q - 1'b1;
        end else if (b_pressed) begin
            speed_d = speed_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            speed_q <= SPEED_INIT;
        end else begin
            speed_q <= speed_d;
        end
    end

    for (genvar g = 0; g < (1 << SPEED_W); g++) begin : g_lut
        assign ticks_lut[g] = bpm_to_ticks(64'(FREQ), 64'(BPM_BASE + BPM_STEP * g));
    end

    assign bus.button_a_pressed = a_pressed;
    assign bus.button_b_pressed = b_pressed;
    assign bus.speed            = speed_q;
    assign bus.bpm              = 8'(BPM_BASE) + 8'(BPM_STEP) * 8'(speed_q);
    assign bus.bpm_ticks        = ticks_lut[speed_q];

endmodule

// File: tb/tb_metronome_tempo_ctrl.sv
// Directed and randomised checks of metronome_tempo_ctrl against a cycle-level behavioural model.
module tb_metronome_tempo_ctrl;
    import metronome_pkg::*;

    localparam int unsigned DEB  = 8;
    localparam int unsigned FREQ = 24_000_000;
    localparam int          SPEED_INIT = 1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    metronome_tempo_ctrl_if bus();

    always #5 sys_clk = ~sys_clk;

    metronome_tempo_ctrl #(
        .FREQ(FREQ),
        .DEBOUNCE_CYCLES(DEB),
        .SPEED_INIT(4'(SPEED_INIT))
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: pipeline of synced samples, accepted level, run length of disagreement, pulse.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_st [2];
    logic m_pr [2];
    int   m_run [2];
    int   m_speed = SPEED_INIT;

    int step_no = 0;
    int pa_cnt  = 0;
    int pb_cnt  = 0;
    int pb_first = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic raw [2];
        raw[0] = ~bus.button_a_n;
        raw[1] = ~bus.button_b_n;
        if (!sys_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_st[i] = 1'b0; m_pr[i] = 1'b0; m_run[i] = 0;
            end
            m_speed = SPEED_INIT;
        end else begin
            if (m_pr[0])      m_speed = (m_speed + 15) % 16;
            else if (m_pr[1]) m_speed = (m_speed + 1) % 16;
            for (int i = 0; i < 2; i++) begin
                m_pr[i] = 1'b0;
                if (m_s2[i] == m_st[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] == int'(DEB)) begin
                    m_st[i]  = ~m_st[i];
                    m_run[i] = 0;
                    m_pr[i]  = m_st[i];
                end else begin
                    m_run[i]++;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic a_n, input logic b_n);
        longint unsigned exp_bpm, exp_ticks;
        sys_rst_n      = rst_n;
        bus.button_a_n = a_n;
        bus.button_b_n = b_n;
        @(posedge sys_clk);
        model_edge();
        #1;
        step_no++;
        if (bus.button_a_pressed === 1'b1) pa_cnt++;
        if (bus.button_b_pressed === 1'b1) begin
            pb_cnt++;
            if (pb_first < 0) pb_first = step_no;
        end
        exp_bpm   = 64'(60 + 10 * m_speed);
        exp_ticks = (64'(FREQ) * 64'd60) / exp_bpm;
        check("state_a",   32'(bus.button_a_state),   32'(m_st[0]));
        check("state_b",   32'(bus.button_b_state),   32'(m_st[1]));
        check("pressed_a", 32'(bus.button_a_pressed), 32'(m_pr[0]));
        check("pressed_b", 32'(bus.button_b_pressed), 32'(m_pr[1]));
        check("speed",     32'(bus.speed),            32'(m_speed));
        check("bpm",       32'(bus.bpm),              32'(exp_bpm));
        check("bpm_ticks", 32'(bus.bpm_ticks),        32'(exp_ticks));
    endtask

    task automatic press(input logic a, input logic b, input int hold, input int rel);
        for (int i = 0; i < hold; i++) step(1'b1, ~a, ~b);
        for (int i = 0; i < rel; i++)  step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int base, pa0, pb0;
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_st[i] = 1'b0; m_pr[i] = 1'b0; m_run[i] = 0;
        end
        bus.button_a_n = 1'b1;
        bus.button_b_n = 1'b1;

        // 1: reset
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("rst_speed", 32'(bus.speed), 32'd1);
        check("rst_bpm",   32'(bus.bpm), 32'd70);
        check("rst_ticks", 32'(bus.bpm_ticks), 32'd20_571_428);
        check("rst_flags", 32'({bus.button_a_state, bus.button_b_state,
                               bus.button_a_pressed, bus.button_b_pressed}), 32'd0);
        step(1'b1, 1'b1, 1'b1);

        // 2: clean B press, latency and no pulse on release
        base = step_no; pb_first = -1; pb0 = pb_cnt;
        press(1'b0, 1'b1, 20, 0);
        check("b_latency", 32'(pb_first - base - 1), 32'd10);
        check("b_one_pulse", 32'(pb_cnt - pb0), 32'd1);
        press(1'b0, 1'b0, 0, 20);
        check("b_release_pulse", 32'(pb_cnt - pb0), 32'd1);
        check("b_speed", 32'(bus.speed), 32'd2);
        check("b_bpm", 32'(bus.bpm), 32'd80);
        check("b_ticks", 32'(bus.bpm_ticks), 32'd18_000_000);

        // 3: bounced A
        pa0 = pa_cnt;
        press(1'b1, 1'b0, 3, 2);
        press(1'b1, 1'b0, 4, 20);
        check("bounce_pulse", 32'(pa_cnt - pa0), 32'd0);
        check("bounce_speed", 32'(bus.speed), 32'd2);

        // 4: wrap, starting from a fresh reset so speed begins at 1
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        press(1'b1, 1'b0, 12, 12);
        check("wrap_0", 32'(bus.speed), 32'd0);
        press(1'b1, 1'b0, 12, 12);
        check("wrap_15", 32'(bus.speed), 32'd15);
        check("wrap_15_ticks", 32'(bus.bpm_ticks), 32'd6_857_142);
        press(1'b0, 1'b1, 12, 12);
        check("wrap_up_0", 32'(bus.speed), 32'd0);
        check("wrap_up_ticks", 32'(bus.bpm_ticks), 32'd24_000_000);

        // 5: simultaneous press, A has priority
        press(1'b1, 1'b1, 12, 12);
        check("both_speed", 32'(bus.speed), 32'd15);

        // 6: reset while B is mid-debounce
        pb0 = pb_cnt;
        press(1'b0, 1'b1, 7, 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b0, 0, 20);
        check("midrst_pulse", 32'(pb_cnt - pb0), 32'd0);
        check("midrst_speed", 32'(bus.speed), 32'd1);

        // Random segments of button levels with occasional resets
        for (int s = 0; s < 80; s++) begin
            logic a, b, r;
            int len;
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 19) != 0);
            len = r ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 2));
            for (int k = 0; k < len; k++) step(r, ~a, ~b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
